// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus codes, controller state encoding and the stall-bus bundle.
package pipe_stall_ctrl_pkg;

    // bit[0] = stall, bit[1] = hold; 2'b10 is reserved and never driven.
    typedef enum logic [1:0] {
        STALL_GO     = 2'b00,
        STALL_BUBBLE = 2'b01,
        STALL_HOLD   = 2'b11
    } stall_code_t;

    typedef enum logic {
        SC_RUN      = 1'b0,
        SC_MEM_WAIT = 1'b1
    } sc_state_t;

    typedef struct packed {
        logic        pc;
        stall_code_t if_id;
        stall_code_t id_ex;
        stall_code_t ex_mem;
        stall_code_t mem_wb;
    } stall_bus_t;

endpackage

// File: rtl/pipe_stall_ctrl_stall_stat_cnt.sv
// Free-running (wrapping) event counter with enable, used for stall statistics.
module stall_stat_cnt #(
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    localparam logic [STAT_W-1:0] ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: memory wait, EX flush and load-use arbitration.
// Optional statistics counters are built only when STALL_STATS_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_stallreq,
    input  logic              ex_flush,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic [1:0]        stall_if_id,
    output logic [1:0]        stall_id_ex,
    output logic [1:0]        stall_ex_mem,
    output logic [1:0]        stall_mem_wb,
    output logic              mem_timeout,
    output logic [STAT_W-1:0] stat_lu,
    output logic [STAT_W-1:0] stat_mw,
    output logic [STAT_W-1:0] stat_fl
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    sc_state_t        state, state_next;
    logic [CNT_W-1:0] wait_cnt, cnt_next;
    stall_bus_t       bus;
    logic             mem_stall;
    logic             lu_hit, mw_hit, fl_hit;

    always_comb begin
        bus        = '{pc: 1'b0, if_id: STALL_GO, id_ex: STALL_GO,
                       ex_mem: STALL_GO, mem_wb: STALL_GO};
        state_next = state;
        cnt_next   = wait_cnt;
        lu_hit     = 1'b0;
        mw_hit     = 1'b0;
        fl_hit     = 1'b0;
        // Once waiting, only mem_ready matters; a ready access never stalls.
        mem_stall  = (state == SC_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

        if (mem_stall) begin
            bus        = '{pc: 1'b1, if_id: STALL_HOLD, id_ex: STALL_HOLD,
                           ex_mem: STALL_HOLD, mem_wb: STALL_BUBBLE};
            mw_hit     = 1'b1;
            state_next = SC_MEM_WAIT;
            if (state == SC_RUN) begin
                cnt_next = CNT_ONE;
            end else if (wait_cnt != TIMEOUT_VAL) begin
                cnt_next = wait_cnt + CNT_ONE;
            end
        end else begin
            state_next = SC_RUN;
            cnt_next   = '0;
            if (ex_flush) begin
                bus.if_id = STALL_BUBBLE;
                bus.id_ex = STALL_BUBBLE;
                fl_hit    = 1'b1;
            end else if (id_stallreq) begin
                bus.pc    = 1'b1;
                bus.if_id = STALL_HOLD;
                bus.id_ex = STALL_BUBBLE;
                lu_hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SC_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= cnt_next;
            mem_timeout <= (cnt_next == TIMEOUT_VAL) && (wait_cnt != TIMEOUT_VAL);
        end
    end

    // Outputs are forced to GO while reset is held, independent of the inputs.
    assign pc_stall     = rst && bus.pc;
    assign stall_if_id  = rst ? bus.if_id  : STALL_GO;
    assign stall_id_ex  = rst ? bus.id_ex  : STALL_GO;
    assign stall_ex_mem = rst ? bus.ex_mem : STALL_GO;
    assign stall_mem_wb = rst ? bus.mem_wb : STALL_GO;

`ifdef STALL_STATS_EN
    stall_stat_cnt #(.STAT_W(STAT_W)) u_cnt_lu (
        .clk(clk), .rst(rst), .en(lu_hit), .count(stat_lu)
    );
    stall_stat_cnt #(.STAT_W(STAT_W)) u_cnt_mw (
        .clk(clk), .rst(rst), .en(mw_hit), .count(stat_mw)
    );
    stall_stat_cnt #(.STAT_W(STAT_W)) u_cnt_fl (
        .clk(clk), .rst(rst), .en(fl_hit), .count(stat_fl)
    );
`else
    logic unused_hits;
    assign unused_hits = &{1'b0, lu_hit, mw_hit, fl_hit};
    assign stat_lu     = '0;
    assign stat_mw     = '0;
    assign stat_fl     = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model (MEM_TIMEOUT reduced to 4).
module tb_pipe_stall_ctrl;

    localparam int unsigned T      = 4;
    localparam int unsigned STAT_W = 32;

    localparam logic [8:0] GO9 = 9'b0_00_00_00_00;
    localparam logic [8:0] LU9 = 9'b1_11_01_00_00;
    localparam logic [8:0] FL9 = 9'b0_01_01_00_00;
    localparam logic [8:0] MW9 = 9'b1_11_11_11_01;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_stallreq, ex_flush, mem_req, mem_ready;
    logic              pc_stall, mem_timeout;
    logic [1:0]        stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic [STAT_W-1:0] stat_lu, stat_mw, stat_fl;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pipe_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .id_stallreq(id_stallreq), .ex_flush(ex_flush),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .mem_timeout(mem_timeout),
        .stat_lu(stat_lu), .stat_mw(stat_mw), .stat_fl(stat_fl)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {pc_stall, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb};
    endfunction

    // Apply inputs just after the falling edge; outputs settle well before the next rise.
    task automatic drive(input logic i, input logic f, input logic q, input logic r);
        @(negedge clk);
        id_stallreq = i; ex_flush = f; mem_req = q; mem_ready = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        id_stallreq = 1'b1; ex_flush = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        #3;
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL reset_codes got %b exp %b", obs(), GO9);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout);
        end
        checks++;
        if ({stat_lu, stat_mw, stat_fl} !== '0) begin
            errors++; $display("FAIL reset_stats got %0d %0d %0d exp 0", stat_lu, stat_mw, stat_fl);
        end
        @(negedge clk);
        id_stallreq = 1'b0; mem_req = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0);
        checks++;
        if (obs() !== LU9) begin
            errors++; $display("FAIL load_use got %b exp %b", obs(), LU9);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL load_use_after got %b exp %b", obs(), GO9);
        end
    endtask

    task automatic test_flush_lu();
        logic [STAT_W-1:0] lu0, fl0;
        drive(0, 0, 0, 0);
        lu0 = stat_lu; fl0 = stat_fl;
        drive(1, 1, 0, 0);
        checks++;
        if (obs() !== FL9) begin
            errors++; $display("FAIL flush_lu got %b exp %b", obs(), FL9);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL flush_after got %b exp %b", obs(), GO9);
        end
`ifdef STALL_STATS_EN
        checks++;
        if (stat_fl !== fl0 + 1 || stat_lu !== lu0) begin
            errors++; $display("FAIL flush_stats got fl=%0d lu=%0d exp fl=%0d lu=%0d",
                               stat_fl, stat_lu, fl0 + 1, lu0);
        end
`endif
    endtask

    task automatic test_mem_wait();
        logic [STAT_W-1:0] mw0;
        drive(0, 0, 0, 0);
        mw0 = stat_mw;
        for (int i = 0; i < 3; i++) begin
            // Hazards raised during the wait must be ignored.
            drive(i == 1, i == 1, 1, 0);
            checks++;
            if (obs() !== MW9) begin
                errors++; $display("FAIL mem_wait[%0d] got %b exp %b", i, obs(), MW9);
            end
        end
        drive(0, 0, 1, 1);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL mem_release got %b exp %b", obs(), GO9);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL mem_after got %b exp %b", obs(), GO9);
        end
`ifdef STALL_STATS_EN
        checks++;
        if (stat_mw !== mw0 + 3) begin
            errors++; $display("FAIL mem_stats got %0d exp %0d", stat_mw, mw0 + 3);
        end
`endif
    endtask

    task automatic test_release_rules();
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 1);
        checks++;
        if (obs() !== FL9) begin
            errors++; $display("FAIL release_flush got %b exp %b", obs(), FL9);
        end
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 1);
        checks++;
        if (obs() !== LU9) begin
            errors++; $display("FAIL release_lu got %b exp %b", obs(), LU9);
        end
    endtask

    task automatic test_zero_wait();
        drive(0, 0, 1, 1);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL zero_wait got %b exp %b", obs(), GO9);
        end
        drive(1, 0, 1, 1);
        checks++;
        if (obs() !== LU9) begin
            errors++; $display("FAIL zero_wait_lu got %b exp %b", obs(), LU9);
        end
        // Still in RUN: an idle cycle with mem_ready low must not stall.
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL zero_wait_state got %b exp %b", obs(), GO9);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0);
            if (mem_timeout === 1'b1) pulses++;
            checks++;
            if (obs() !== MW9 || mem_timeout !== (i == T)) begin
                errors++; $display("FAIL timeout[%0d] got %b/%b exp %b/%b",
                                   i, obs(), mem_timeout, MW9, (i == T));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses);
        end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_after got %b/%b exp %b/0", obs(), mem_timeout, GO9);
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== GO9 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL midreset_async got %b/%b exp %b/0", obs(), mem_timeout, GO9);
        end
        mem_req = 1'b0; mem_ready = 1'b0;
        #1 rst = 1'b1;
        drive(0, 0, 0, 0);
        checks++;
        if (obs() !== GO9) begin
            errors++; $display("FAIL midreset_state got %b exp %b", obs(), GO9);
        end
        checks++;
        if ({stat_lu, stat_mw, stat_fl} !== '0) begin
            errors++; $display("FAIL midreset_stats got %0d %0d %0d exp 0", stat_lu, stat_mw, stat_fl);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 0);
            checks++;
            if (mem_timeout !== (i == T)) begin
                errors++; $display("FAIL midreset_cnt[%0d] got %b exp %b", i, mem_timeout, (i == T));
            end
        end
        drive(0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit          waiting = 0, exp_to = 0, stall;
        int unsigned len = 0;
        int unsigned n_lu = 0, n_mw = 0, n_fl = 0;
        logic        i, f, q, r;
        logic [8:0]  exp;
        drive(0, 0, 0, 0);
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            i = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 9) < 2);
            q = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 9) < 3);
            drive(i, f, q, r);
            stall = waiting ? !r : (q && !r);
            exp = stall ? MW9 : f ? FL9 : i ? LU9 : GO9;
            checks++;
            if (obs() !== exp || mem_timeout !== exp_to) begin
                errors++; $display("FAIL rand[%0d] got %b/%b exp %b/%b", k, obs(), mem_timeout, exp, exp_to);
            end
`ifdef STALL_STATS_EN
            checks++;
            if (stat_lu !== n_lu || stat_mw !== n_mw || stat_fl !== n_fl) begin
                errors++; $display("FAIL rand_stats[%0d] got %0d %0d %0d exp %0d %0d %0d",
                                   k, stat_lu, stat_mw, stat_fl, n_lu, n_mw, n_fl);
            end
`else
            checks++;
            if ({stat_lu, stat_mw, stat_fl} !== '0) begin
                errors++; $display("FAIL rand_stats[%0d] got nonzero exp 0", k);
            end
`endif
            if ($urandom_range(0, 63) == 0) begin
                #1 rst = 1'b0;
                #1;
                checks++;
                if (obs() !== GO9 || mem_timeout !== 1'b0) begin
                    errors++; $display("FAIL rand_rst[%0d] got %b/%b exp %b/0", k, obs(), mem_timeout, GO9);
                end
                rst = 1'b1;
                waiting = 0; len = 0; exp_to = 0; n_lu = 0; n_mw = 0; n_fl = 0;
                stall = q && !r;
            end
            // Advance the model by the rising edge that follows.
            if (stall) begin
                len     = waiting ? len + 1 : 1;
                waiting = 1;
                n_mw++;
                exp_to  = (len == T);
            end else begin
                waiting = 0; len = 0; exp_to = 0;
                if (f) n_fl++;
                else if (i) n_lu++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush_lu();
        test_mem_wait();
        test_release_rules();
        test_zero_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
